// File: rtl/multiword_add_sequencer_if.sv
// multiword_add_sequencer_if: operand request / result handshake bundle for the multi-precision adder
interface multiword_add_sequencer_if #(parameter int WORDS = 4);
  localparam int WIDTH = 8 * WORDS;
  logic in_valid;
  logic in_ready;
  logic sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic cout;
  logic ovf;
  logic busy;
  modport master (
    output in_valid, sub, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );
  modport slave (
    input  in_valid, sub, a, b, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: WORDS x 8-bit add/subtract on one shared 8-bit ripple slice, LS byte first
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst,
  multiword_add_sequencer_if.slave bus
);
  localparam int WIDTH = 8 * WORDS;
  localparam int KW = $clog2(WORDS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [KW-1:0] k;
  logic c, cout_q, ovf_q, last, accept;
  logic [7:0] sa, sb, ss;
  logic [8:0] rc;
  assign accept = state == IDLE && bus.in_valid;
  assign last = k == KW'(WORDS - 1);
  assign sa = a_q[8*k +: 8];
  assign sb = b_q[8*k +: 8];
  // Shared 8-bit ripple-carry slice; rc[0] is the inter-cycle carry register
  always_comb begin
    rc = '0;
    ss = '0;
    rc[0] = c;
    for (int i = 0; i < 8; i++) begin
      ss[i] = sa[i] ^ sb[i] ^ rc[i];
      rc[i+1] = (sa[i] & sb[i]) | (rc[i] & (sa[i] ^ sb[i]));
    end
  end
  always_comb begin
    state_next = state;
    state_next = accept ? RUN :
                 (state == RUN && last) ? DONE :
                 (state == DONE && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      k <= '0;
      c <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      a_q <= bus.a;
      b_q <= bus.sub ? ~bus.b : bus.b;
      c <= bus.sub;
      k <= '0;
    end else if (state == RUN) begin
      sum_q[8*k +: 8] <= ss;
      c <= rc[8];
      k <= k + 1'b1;
      if (last) begin
        cout_q <= rc[8];
        ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ss[7] != a_q[WIDTH-1]);
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: directed and randomized checks of the multi-precision add/sub sequencer
module tb_multiword_add_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  multiword_add_sequencer_if #(.WORDS(4)) b4();
  multiword_add_sequencer_if #(.WORDS(2)) b2();
  multiword_add_sequencer #(.WORDS(4)) dut4(.clk(clk), .rst(rst), .bus(b4.slave));
  multiword_add_sequencer #(.WORDS(2)) dut2(.clk(clk), .rst(rst), .bus(b2.slave));
  int compared = 0;
  int mismatched = 0;

  // Arithmetic reference: unsigned result mod 2^w, no-borrow/carry flag, signed range overflow
  function automatic void model(input int w, input longint av, input longint bv, input logic s,
                                output longint r, output logic co, output logic ov);
    longint m, sa, sb, t;
    m = longint'(1) << w;
    sa = (av >= m / 2) ? av - m : av;
    sb = (bv >= m / 2) ? bv - m : bv;
    t = s ? sa - sb : sa + sb;
    r = (s ? av - bv : av + bv) & (m - 1);
    co = s ? (av >= bv) : (av + bv >= m);
    ov = (t < -(m / 2)) || (t >= m / 2);
  endfunction

  task automatic op4(input logic [31:0] av, input logic [31:0] bv, input logic s, output int n);
    @(negedge clk);
    b4.a = av; b4.b = bv; b4.sub = s; b4.in_valid = 1'b1;
    n = 0;
    while (!b4.in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    n = 1;
    while (!b4.out_valid && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic consume4;
    b4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.out_ready = 1'b0;
  endtask

  task automatic op2(input logic [15:0] av, input logic [15:0] bv, input logic s, output int n);
    @(negedge clk);
    b2.a = av; b2.b = bv; b2.sub = s; b2.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b2.in_valid = 1'b0;
    n = 1;
    while (!b2.out_valid && n < 50) begin @(negedge clk); n++; end
  endtask

  task automatic consume2;
    b2.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b2.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    compared++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.busy !== 1'b0) begin
      mismatched++; $display("FAIL reset flags: got rdy=%b vld=%b busy=%b want 1 0 0", b4.in_ready, b4.out_valid, b4.busy);
    end
    compared++; if (b4.sum !== 32'h0 || b4.cout !== 1'b0 || b4.ovf !== 1'b0) begin
      mismatched++; $display("FAIL reset result: got sum=%h cout=%b ovf=%b want 0 0 0", b4.sum, b4.cout, b4.ovf);
    end
    compared++; if (b2.in_ready !== 1'b1 || b2.out_valid !== 1'b0 || b2.sum !== 16'h0) begin
      mismatched++; $display("FAIL reset words2: got rdy=%b vld=%b sum=%h want 1 0 0000", b2.in_ready, b2.out_valid, b2.sum);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] va[6], vb[6], vs[6];
    logic vsub[6], vc[6], vo[6];
    int n;
    va = '{32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000005, 32'h00000007, 32'h80000000};
    vb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000007, 32'h00000005, 32'h00000001};
    vsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vs = '{32'h00000100, 32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h00000002, 32'h7FFFFFFF};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      op4(va[i], vb[i], vsub[i], n);
      compared++; if (n !== 5) begin
        mismatched++; $display("FAIL directed[%0d] latency: got %0d want 5", i, n);
      end
      compared++; if (b4.sum !== vs[i] || b4.cout !== vc[i] || b4.ovf !== vo[i]) begin
        mismatched++; $display("FAIL directed[%0d] result: got %h/%b/%b want %h/%b/%b", i, b4.sum, b4.cout, b4.ovf, vs[i], vc[i], vo[i]);
      end
      compared++; if (b4.busy !== 1'b1 || b4.in_ready !== 1'b0) begin
        mismatched++; $display("FAIL directed[%0d] done flags: got busy=%b rdy=%b want 1 0", i, b4.busy, b4.in_ready);
      end
      consume4();
      compared++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin
        mismatched++; $display("FAIL directed[%0d] post-consume: got rdy=%b vld=%b want 1 0", i, b4.in_ready, b4.out_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] av, bv;
    logic s, co, ov;
    longint r;
    int n;
    for (int i = 0; i < 40; i++) begin
      av = $urandom; bv = $urandom; s = 1'($urandom_range(0, 1));
      if (i % 8 == 0) bv = av;
      model(32, longint'(av), longint'(bv), s, r, co, ov);
      op4(av, bv, s, n);
      compared++; if (n !== 5) begin
        mismatched++; $display("FAIL random[%0d] latency: got %0d want 5", i, n);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      compared++; if (b4.sum !== r[31:0] || b4.cout !== co || b4.ovf !== ov) begin
        mismatched++; $display("FAIL random[%0d] %h %s %h: got %h/%b/%b want %h/%b/%b", i, av, s ? "-" : "+", bv, b4.sum, b4.cout, b4.ovf, r[31:0], co, ov);
      end
      consume4();
    end
  endtask

  task automatic test_backpressure;
    int n;
    @(negedge clk);
    b4.a = 32'h40000000; b4.b = 32'h40000000; b4.sub = 1'b0; b4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.a = 32'h12345678; b4.b = 32'h12345678; b4.sub = 1'b1;
    n = 1;
    while (!b4.out_valid && n < 50) begin @(negedge clk); n++; end
    compared++; if (n !== 5) begin
      mismatched++; $display("FAIL backpressure latency: got %0d want 5", n);
    end
    for (int i = 0; i < 3; i++) begin
      compared++; if (b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0 || b4.sum !== 32'h80000000 || b4.cout !== 1'b0 || b4.ovf !== 1'b1) begin
        mismatched++; $display("FAIL backpressure hold[%0d]: got vld=%b rdy=%b %h/%b/%b want 1 0 80000000/0/1", i, b4.out_valid, b4.in_ready, b4.sum, b4.cout, b4.ovf);
      end
      @(negedge clk);
    end
    b4.in_valid = 1'b0;
    consume4();
    compared++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.sum !== 32'h80000000) begin
      mismatched++; $display("FAIL backpressure release: got rdy=%b vld=%b sum=%h want 1 0 80000000", b4.in_ready, b4.out_valid, b4.sum);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    int n;
    @(negedge clk);
    b4.a = 32'h00FF00FF; b4.b = 32'h00010001; b4.sub = 1'b0; b4.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++; if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.sum !== 32'h0 || b4.busy !== 1'b0) begin
      mismatched++; $display("FAIL reset mid-run: got rdy=%b vld=%b sum=%h busy=%b want 1 0 0 0", b4.in_ready, b4.out_valid, b4.sum, b4.busy);
    end
    repeat (10) begin @(negedge clk); if (b4.out_valid) seen++; end
    compared++; if (seen !== 0) begin
      mismatched++; $display("FAIL aborted result emitted: got %0d valid cycles want 0", seen);
    end
    op4(32'h01010101, 32'h01010101, 1'b0, n);
    compared++; if (n !== 5 || b4.sum !== 32'h02020202 || b4.cout !== 1'b0) begin
      mismatched++; $display("FAIL after reset op: got lat=%0d %h/%b want 5 02020202/0", n, b4.sum, b4.cout);
    end
    consume4();
  endtask

  task automatic test_back_to_back;
    int hits[$];
    logic [31:0] av, bv;
    logic s, co, ov;
    longint r;
    av = $urandom; bv = $urandom; s = 1'($urandom_range(0, 1));
    model(32, longint'(av), longint'(bv), s, r, co, ov);
    @(negedge clk);
    b4.a = av; b4.b = bv; b4.sub = s; b4.in_valid = 1'b1; b4.out_ready = 1'b1;
    for (int i = 0; i < 40 && hits.size() < 4; i++) begin
      @(negedge clk);
      if (b4.out_valid) begin
        hits.push_back(i);
        compared++; if (b4.sum !== r[31:0] || b4.cout !== co || b4.ovf !== ov) begin
          mismatched++; $display("FAIL back_to_back result: got %h/%b/%b want %h/%b/%b", b4.sum, b4.cout, b4.ovf, r[31:0], co, ov);
        end
      end
    end
    b4.in_valid = 1'b0;
    compared++; if (hits.size() !== 4) begin
      mismatched++; $display("FAIL back_to_back count: got %0d results want 4", hits.size());
    end
    for (int i = 1; i < hits.size(); i++) begin
      compared++; if (hits[i] - hits[i-1] !== 6) begin
        mismatched++; $display("FAIL back_to_back spacing[%0d]: got %0d want 6", i, hits[i] - hits[i-1]);
      end
    end
    repeat (10) @(negedge clk);
    b4.out_ready = 1'b0;
  endtask

  task automatic test_words2;
    logic [15:0] av, bv;
    logic s, co, ov;
    longint r;
    int n;
    op2(16'hFFFF, 16'hFFFF, 1'b0, n);
    compared++; if (n !== 3 || b2.sum !== 16'hFFFE || b2.cout !== 1'b1 || b2.ovf !== 1'b0) begin
      mismatched++; $display("FAIL words2 directed: got lat=%0d %h/%b/%b want 3 fffe/1/0", n, b2.sum, b2.cout, b2.ovf);
    end
    consume2();
    for (int i = 0; i < 12; i++) begin
      av = 16'($urandom); bv = 16'($urandom); s = 1'($urandom_range(0, 1));
      model(16, longint'(av), longint'(bv), s, r, co, ov);
      op2(av, bv, s, n);
      compared++; if (n !== 3 || b2.sum !== r[15:0] || b2.cout !== co || b2.ovf !== ov) begin
        mismatched++; $display("FAIL words2 random[%0d] %h %s %h: got lat=%0d %h/%b/%b want 3 %h/%b/%b", i, av, s ? "-" : "+", bv, n, b2.sum, b2.cout, b2.ovf, r[15:0], co, ov);
      end
      consume2();
    end
  endtask

  initial begin
    b4.in_valid = 1'b0; b4.sub = 1'b0; b4.a = '0; b4.b = '0; b4.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.sub = 1'b0; b2.a = '0; b2.b = '0; b2.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_words2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
